// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared state encoding, LCD command constants and long-command classifier
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;

    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_FUNC_SET = 8'h3C;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] DDRAM_LINE1  = 8'h80;
    localparam logic [7:0] DDRAM_LINE2  = 8'hC0;

    // Clear (0x01) and return-home (0x02/0x03) need the long execution delay.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return (!rs) && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// rtl/lcd_delay_counter.sv - loadable down-counter with zero flag, parks at zero
module lcd_delay_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/lcd_byte_writer.sv
// rtl/lcd_byte_writer.sv - HD44780 bus-timing stage: one E pulse per accepted {RS, DATA} byte
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 12,
    parameter int HOLD_CYC  = 2,
    parameter int EXEC_CYC  = 50,
    parameter int CLR_CYC   = 2000,
    parameter int CNT_W     = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       IN_VALID,
    output logic       IN_READY,
    input  logic       IN_RS,
    input  logic [7:0] IN_DATA,
    output logic       BUSY,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA
);

    localparam int S_EFF = (SETUP_CYC < 1) ? 1 : SETUP_CYC;

    state_t           state_q, state_d;
    logic             lcd_e_q, lcd_e_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic [7:0]       lcd_data_q, lcd_data_d;
    logic             xfer;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_zero;

    assign xfer = IN_VALID && (state_q == ST_IDLE);

    lcd_delay_counter #(.CNT_W(CNT_W)) u_delay (
        .clk      (CLK),
        .reset    (RESET),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            lcd_e_q    <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            lcd_e_q    <= lcd_e_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_data_q <= lcd_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (xfer)     state_d = ST_SETUP;
            ST_SETUP: if (cnt_zero) state_d = ST_PULSE;
            ST_PULSE: if (cnt_zero) state_d = ST_HOLD;
            ST_HOLD:  if (cnt_zero) state_d = ST_WAIT;
            ST_WAIT:  if (cnt_zero) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Counter is reloaded with N-1 on every state entry; the latched byte picks the WAIT length.
    always_comb begin
        lcd_e_d      = (state_d == ST_PULSE);
        lcd_rs_d     = xfer ? IN_RS   : lcd_rs_q;
        lcd_data_d   = xfer ? IN_DATA : lcd_data_q;
        cnt_load     = (state_d != state_q);
        cnt_load_val = '0;
        case (state_d)
            ST_SETUP: cnt_load_val = CNT_W'(S_EFF - 1);
            ST_PULSE: cnt_load_val = CNT_W'(PULSE_CYC - 1);
            ST_HOLD:  cnt_load_val = CNT_W'(HOLD_CYC - 1);
            ST_WAIT:  cnt_load_val = is_long_cmd(lcd_rs_q, lcd_data_q) ? CNT_W'(CLR_CYC - 1)
                                                                       : CNT_W'(EXEC_CYC - 1);
            default:  cnt_load_val = '0;
        endcase
    end

    assign IN_READY = (state_q == ST_IDLE);
    assign BUSY     = ~IN_READY;
    assign LCD_E    = lcd_e_q;
    assign LCD_RS   = lcd_rs_q;
    assign LCD_DATA = lcd_data_q;
    assign LCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// tb/tb_lcd_byte_writer.sv - self-checking bench for lcd_byte_writer against a timeline model
module tb_lcd_byte_writer;
    import lcd_pkg::*;

    localparam int S  = 2;
    localparam int P  = 4;
    localparam int H  = 2;
    localparam int EX = 5;
    localparam int CL = 20;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       IN_VALID;
    logic       IN_READY;
    logic       IN_RS;
    logic [7:0] IN_DATA;
    logic       BUSY;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DATA;

    lcd_byte_writer #(
        .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H),
        .EXEC_CYC(EX), .CLR_CYC(CL), .CNT_W(16)
    ) dut (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_RS(IN_RS), .IN_DATA(IN_DATA), .BUSY(BUSY), .LCD_E(LCD_E),
        .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Model: time since the last accepted byte decides everything.
    bit         m_active = 1'b0;
    int         m_d = 0;
    int         m_len = 0;
    logic       m_rs = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_e = 1'b0;
    logic       m_ready = 1'b1;
    int         m_xfers = 0;
    int         edge_no = 0;

    logic [12:0] got;
    logic [12:0] exp_v;

    function automatic bit long_cmd(input logic rs, input logic [7:0] d);
        return (rs == 1'b0) && (d >= 8'd1) && (d <= 8'd3);
    endfunction

    task automatic tick();
        bit fire;
        fire = IN_VALID && m_ready && !RESET;
        @(posedge CLK);
        edge_no++;
        if (RESET) begin
            m_active = 1'b0;
            m_rs     = 1'b0;
            m_data   = 8'h00;
        end else if (fire) begin
            m_active = 1'b1;
            m_d      = 0;
            m_rs     = IN_RS;
            m_data   = IN_DATA;
            m_len    = S + P + H + (long_cmd(IN_RS, IN_DATA) ? CL : EX);
            m_xfers++;
        end else if (m_active) begin
            m_d++;
            if (m_d >= m_len) m_active = 1'b0;
        end
        m_ready = !m_active;
        m_e     = m_active && (m_d >= S) && (m_d < S + P);
        #1;
        got   = {LCD_E, LCD_RS, LCD_DATA, LCD_RW, IN_READY, BUSY};
        exp_v = {m_e, m_rs, m_data, 1'b0, m_ready, !m_ready};
    endtask

    task automatic test_reset();
        RESET = 1'b1; IN_VALID = 1'b0; IN_RS = 1'b0; IN_DATA = 8'h00;
        repeat (3) tick();
        checks++;
        if (got !== 13'b0_0_00000000_0_1_0) begin
            errors++;
            $display("FAIL reset_state got %b required %b", got, 13'b0_0_00000000_0_1_0);
        end
        RESET = 1'b0;
        tick();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL reset_release got %h required %h", got, exp_v);
        end
    endtask

    // One byte from idle; checks every cycle plus busy length and pulse width.
    task automatic test_single(input string name, input logic rs, input logic [7:0] data,
                               input int exp_busy);
        int busy_cnt;
        int e_cnt;
        int first_e;
        int k;
        IN_VALID = 1'b1; IN_RS = rs; IN_DATA = data;
        tick();
        k = edge_no;
        IN_VALID = 1'b0; IN_RS = ~rs; IN_DATA = ~data;
        busy_cnt = 0; e_cnt = 0; first_e = -1;
        for (int i = 0; i < 100 && !(IN_READY === 1'b1 && busy_cnt > 0); i++) begin
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL %s cycle k+%0d got %h required %h", name, edge_no - k + 1, got, exp_v);
            end
            if (BUSY === 1'b1) busy_cnt++;
            if (LCD_E === 1'b1) begin
                e_cnt++;
                if (first_e < 0) first_e = edge_no - k + 1;
            end
            if (IN_READY !== 1'b1) tick();
        end
        checks++;
        if (busy_cnt != exp_busy) begin
            errors++;
            $display("FAIL %s_busy_len got %0d required %0d", name, busy_cnt, exp_busy);
        end
        checks++;
        if (e_cnt != P || first_e != S + 1) begin
            errors++;
            $display("FAIL %s_pulse got width %0d start k+%0d required width %0d start k+%0d",
                     name, e_cnt, first_e, P, S + 1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        int idx;
        int prev_e;
        int rises [$];
        int start_x;
        bytes[0] = 8'h32; bytes[1] = 8'h30; bytes[2] = 8'h31;
        idx = 0; prev_e = 0; start_x = m_xfers;
        IN_VALID = 1'b1; IN_RS = 1'b0; IN_DATA = bytes[0];
        for (int i = 0; i < 200 && !(idx == 3 && m_ready); i++) begin
            tick();
            idx = m_xfers - start_x;
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL back_to_back edge %0d got %h required %h", edge_no, got, exp_v);
            end
            if (LCD_E === 1'b1 && prev_e == 0) rises.push_back(edge_no);
            prev_e = (LCD_E === 1'b1);
            if (m_ready) begin
                IN_VALID = (idx < 3);
                IN_RS    = 1'b0;
                IN_DATA  = (idx < 3) ? bytes[idx] : 8'h00;
            end else begin
                IN_RS   = 1'($urandom);
                IN_DATA = 8'($urandom);
            end
        end
        IN_VALID = 1'b0;
        checks++;
        if (rises.size() != 3) begin
            errors++;
            $display("FAIL back_to_back_pulses got %0d required 3", rises.size());
        end else begin
            checks++;
            if (rises[1] - rises[0] != S + P + H + EX + 1 || rises[2] - rises[1] != S + P + H + EX + 1) begin
                errors++;
                $display("FAIL back_to_back_period got %0d,%0d required %0d",
                         rises[1] - rises[0], rises[2] - rises[1], S + P + H + EX + 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        d = 8'($urandom_range(32, 126));
        IN_VALID = 1'b1; IN_RS = 1'b1; IN_DATA = d;
        tick();
        IN_VALID = 1'b0;
        for (int i = 0; i < 20 && m_d != S + 1; i++) tick();
        checks++;
        if (LCD_E !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre_e got %b required 1", LCD_E);
        end
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        checks++;
        if (LCD_E !== 1'b0 || IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_abort got e=%b ready=%b required e=0 ready=1", LCD_E, IN_READY);
        end
        for (int i = 0; i < 30; i++) begin
            IN_RS = 1'($urandom); IN_DATA = 8'($urandom);
            tick();
            checks++;
            if (LCD_E !== 1'b0 || got !== exp_v) begin
                errors++;
                $display("FAIL reset_mid_quiet cycle %0d got %h required %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_random();
        int prev_e;
        int rises;
        int start_x;
        logic [7:0] pick [10];
        pick[0] = CMD_CLEAR;   pick[1] = CMD_HOME;    pick[2] = CMD_FUNC_SET;
        pick[3] = CMD_DISP_ON; pick[4] = CMD_ENTRY;   pick[5] = DDRAM_LINE1;
        pick[6] = DDRAM_LINE2; pick[7] = 8'h03;       pick[8] = 8'h04;
        pick[9] = 8'h00;
        prev_e = 0; rises = 0; start_x = m_xfers;
        for (int i = 0; i < 600; i++) begin
            IN_VALID = ($urandom_range(0, 3) != 0);
            IN_RS    = 1'($urandom);
            IN_DATA  = ($urandom_range(0, 1) != 0) ? pick[$urandom_range(0, 9)] : 8'($urandom);
            tick();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL random edge %0d got %h required %h", edge_no, got, exp_v);
            end
            if (LCD_E === 1'b1 && prev_e == 0) rises++;
            prev_e = (LCD_E === 1'b1);
        end
        IN_VALID = 1'b0;
        for (int i = 0; i < 100 && !m_ready; i++) begin
            tick();
            if (LCD_E === 1'b1 && prev_e == 0) rises++;
            prev_e = (LCD_E === 1'b1);
        end
        checks++;
        if (rises != m_xfers - start_x) begin
            errors++;
            $display("FAIL random_pulse_count got %0d required %0d", rises, m_xfers - start_x);
        end
    endtask

    initial begin
        RESET = 1'b1; IN_VALID = 1'b0; IN_RS = 1'b0; IN_DATA = 8'h00;
        #1;
        test_reset();
        test_single("data_4b", 1'b1, 8'h4B, S + P + H + EX);
        test_single("clear_01", 1'b0, CMD_CLEAR, S + P + H + CL);
        test_back_to_back();
        test_single("cls_line1", 1'b0, DDRAM_LINE1, S + P + H + EX);
        test_single("cls_home3", 1'b0, 8'h03, S + P + H + CL);
        test_single("cls_rs1_01", 1'b1, 8'h01, S + P + H + EX);
        test_reset_mid();
        test_single("after_reset", 1'b0, CMD_ENTRY, S + P + H + EX);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
